// File: rtl/parity_frame_ctrl.sv
// Serial parity framer: shifts a parallel word out LSB first,
// appends one parity beat, and counts completed frames.
module parity_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        cnt_q, cnt_d;

  // Next-state and state-decoded handshake/serial outputs.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          acc_d   = 1'b0;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = shreg_q[0];
        if (out_ready) begin
          acc_d   = acc_q ^ shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = PAR;
          end
        end
      end
      PAR: begin
        out_valid = 1'b1;
        out_bit   = acc_q ^ ODD;
        out_last  = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl: even and odd instances
// share stimulus; frames are checked beat by beat.
module tb_parity_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       in_ready0, out_valid0, out_bit0, out_last0, busy0;
  logic [7:0] cnt0;
  logic       in_ready1, out_valid1, out_bit1, out_last1, busy1;
  logic [7:0] cnt1;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  parity_frame_ctrl #(.DATA_W(8), .ODD(1'b0)) u_even (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_bit   (out_bit0),
    .out_last  (out_last0),
    .busy      (busy0),
    .frame_cnt (cnt0)
  );

  parity_frame_ctrl #(.DATA_W(8), .ODD(1'b1)) u_odd (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_bit   (out_bit1),
    .out_last  (out_last1),
    .busy      (busy1),
    .frame_cnt (cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready0, 1);
    chk({tag, "_out_valid"}, out_valid0, 0);
    chk({tag, "_out_bit"}, out_bit0, 0);
    chk({tag, "_out_last"}, out_last0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_busy_odd"}, busy1, 0);
    chk({tag, "_cnt"}, cnt0, exp_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
  endtask

  // Called and returns at a falling edge.
  // mode 0: out_ready held high; mode 1: random with a 5-cycle stall.
  task automatic send(input logic [7:0] d, input logic [7:0] bits,
                      input logic pe, input logic po, input int mode,
                      input bit hold_valid, input logic [7:0] next_d,
                      input bit imm);
    int   w = 0;
    int   c = 0;
    int   nb = 0;
    bit   stalled = 1'b0;
    logic pb = 1'b0;
    logic pl = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("accept_timeout", w, 0);
    if (imm) chk("b2b_gap", w, 0);
    out_ready = 1'b1;
    @(negedge clk);
    c = 1;
    in_valid = hold_valid;
    in_data  = hold_valid ? next_d : ~d;
    while (nb < 9 && c < 200) begin
      if (mode == 1)
        out_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
      else
        out_ready = 1'b1;
      chk("out_valid", out_valid0, 1);
      chk("in_ready_low", in_ready0, 0);
      chk("busy", busy0, 1);
      if (stalled) begin
        chk("hold_bit", out_bit0, pb);
        chk("hold_last", out_last0, pl);
      end
      if (out_ready) begin
        if (nb < 8) begin
          chk("data_bit", out_bit0, bits[nb]);
          chk("data_bit_odd", out_bit1, bits[nb]);
          chk("last_low", out_last0, 0);
        end else begin
          chk("par_even", out_bit0, pe);
          chk("par_odd", out_bit1, po);
          chk("last_high", out_last0, 1);
          chk("last_high_odd", out_last1, 1);
        end
        nb++;
      end
      stalled = !out_ready;
      pb = out_bit0;
      pl = out_last0;
      @(negedge clk);
      c++;
    end
    if (nb < 9) chk("beat_timeout", nb, 9);
    exp_cnt = exp_cnt + 8'd1;
    chk("end_in_ready", in_ready0, 1);
    chk("end_out_valid", out_valid0, 0);
    chk("end_busy", busy0, 0);
    chk("frame_cnt", cnt0, exp_cnt);
    chk("frame_cnt_odd", cnt1, exp_cnt);
    if (mode == 0) chk("ready_latency", c, 10);
    if (!hold_valid) in_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] bits;
    logic       pe;
    logic       po;
    int         mode;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{8'hA5, 8'b1010_0101, 1'b0, 1'b1, 0};
    vt[1] = '{8'h07, 8'b0000_0111, 1'b1, 1'b0, 0};
    vt[2] = '{8'h3C, 8'b0011_1100, 1'b0, 1'b1, 1};
    vt[3] = '{8'h00, 8'b0000_0000, 1'b0, 1'b1, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    exp_cnt   = 8'd0;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_cnt_odd", cnt1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

    for (int i = 0; i < 4; i++) begin
      send(vt[i].data, vt[i].bits, vt[i].pe, vt[i].po,
           vt[i].mode, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
    end

    // Back-to-back: producer holds in_valid with the next word.
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 0, 1'b1, 8'h01, 1'b0);
    send(8'h01, 8'h01, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);

    // Reset after four data beats aborts the frame.
    in_valid = 1'b1;
    in_data  = 8'h55;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", busy0, 1);
    do_reset();
    chk_idle("abort");
    chk("abort_cnt", cnt0, 0);
    send(8'h80, 8'h80, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0);

    // Counter wrap over 256 zero frames.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0);
      if (i == 254) chk("cnt_255", cnt0, 255);
      if (i == 255) chk("cnt_wrap", cnt0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
